uart_rx_top: RTL and testbench
==============================

# uart_rx_top

Serial receive stage of the UART 16550 datapath: it is the receive-side counterpart of `uart_tx_top` and consumes the `tx` line it produces, either in loopback or from an external link. The block synchronises the `rx` line, detects the start bit, and samples each bit at its midpoint using the shared 16x `baud_pulse`. It reassembles 5–8 data bits, checks parity and stop bit, and pushes one character plus error flags per frame into the RX FIFO.

## Interface
Parameters:
- `SYNC_STAGES`, 2: flip-flop depth of the `rx` synchroniser; minimum 2.
- `OSR`, 16: `baud_pulse` ticks per bit; must be even.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  reset, synchronous and active-high.
- `baud_pulse`  in  1  one-`clk` strobe at 16x the bit rate, from the same generator that drives `uart_tx_top`.
- `rx`  in  1  serial input, idle high; asynchronous to `clk`.
- `pen`  in  1  parity enable.
- `eps`  in  1  even parity select (1 = even).
- `sticky_parity`  in  1  forced parity: expected bit = `~eps` when `pen`=1.
- `wls`  in  2  word length: 00=5, 01=6, 10=7, 11=8 data bits.
- `dout`  out  8  received character, LSB-aligned; unused upper bits are 0.
- `push`  out  1  one-`clk` write strobe to the RX FIFO.
- `pe`  out  1  parity error for `dout`.
- `fe`  out  1  framing error (stop bit sampled 0).
- `bi`  out  1  break indication (data, parity and stop all 0).

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK_WAIT. All counting advances only on cycles where `baud_pulse`=1.
- IDLE: on a tick with synchronised `rx`=0, clear the tick counter, latch `wls/pen/eps/sticky_parity` into shadow registers, and go to START. Configuration changes mid-frame are ignored.
- START: at tick `OSR/2`, if `rx`=0, restart the counter and go to DATA. If `rx`=1, treat it as a false start and return to IDLE with no push.
- DATA: sample every `OSR` ticks and shift the bit in LSB first. After N bits (N from the latched `wls`), go to PARITY if `pen`, else to STOP.
- PARITY: sample after `OSR` ticks. Expected bit:
  - `sticky_parity`=1: `~eps`.
  - else `eps`=1: XOR of the data bits (even total).
  - else the inverse of that XOR.
  - `pe` = sampled != expected.
- STOP: sample after `OSR` ticks. Only one stop bit is checked regardless of the transmitter's `stb`.
  - `fe` = ~sample.
  - `bi` = data all 0, parity sample 0 (or `pen`=0), and stop 0.
  - Assert `push` and drive `dout/pe/fe/bi`.
  - Next state is BREAK_WAIT if `bi`, else IDLE.
- BREAK_WAIT: stay until synchronised `rx`=1 is seen on a tick, then go to IDLE. A held break yields exactly one push.
- A new start bit may be detected on the first tick after the STOP sample; back-to-back frames with one stop bit are supported.

## Timing
- Reset: state IDLE; synchroniser flops = 1; `dout`=0, `push`=0, `pe`=0, `fe`=0, `bi`=0; counters and shift register = 0.
- `rx` reaches the FSM `SYNC_STAGES` clks after the pin changes.
- `push` is high for exactly one `clk`, in the cycle after the `baud_pulse` that samples the stop bit.
- `dout/pe/fe/bi` become valid in the same cycle as `push` and hold until the next push.
- Frame to push: `OSR/2` + (N + `pen` + 1)·`OSR` ticks after start detection.
- `rst` asserted mid-frame aborts the frame with no push, and the block returns to reset values on the next `clk` edge.

## Structure
- Shared package `uart_pkg`:
  - `rx_state_t` enum.
  - `wls` decode function returning the bit count.
  - Parity function shared with `uart_tx_top`.
  - `OSR` default constant.
- One sub-module, `uart_rx_sync`: a parameterised `SYNC_STAGES` flop chain with reset value 1.
- FSM, counters and shifter stay in `uart_rx_top`.

## Test plan
- Stimulus: `wls`=11, `pen`=1, `eps`=1, `sticky_parity`=0; drive frame 0x13 with parity bit 1 and stop 1 at 16 ticks/bit. Required: one push, `dout`=0x13, `pe`=0, `fe`=0, `bi`=0.
- Stimulus: same configuration with the parity bit driven 0. Required: `dout`=0x13, `pe`=1. Then stop bit driven 0 on the next frame. Required: `fe`=1, `pe`=0.
- Stimulus: hold `rx`=0 for 3 frame times, then release. Required: exactly one push with `dout`=0x00, `bi`=1, `fe`=1, and no further push until `rx` returns high and a new frame arrives.
- Stimulus: a low glitch on `rx` lasting 4 ticks. Required: no push, and the FSM is back in IDLE by tick 8.
- Stimulus: `wls`=00, `pen`=0; send 0x1F. Required: `dout`=0x1F. Changing `wls` to 11 mid-frame gives no change in the result.
- Stimulus: loop `uart_tx_top.tx` to `rx` with identical configuration; send 0x00, 0x55, 0xA5, 0xFF back to back. Required: 4 pushes with matching `dout` and all error flags 0. Assert `rst` during the third frame; required: no push for that frame, and clean reception resumes afterwards.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM states, word-length decode, parity helper.
package uart_pkg;

    localparam int unsigned OSR_DEFAULT = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK_WAIT
    } rx_state_t;

    // Number of data bits selected by the word-length field (5..8).
    function automatic logic [3:0] wls_bits(input logic [1:0] wls);
        return 4'(5) + 4'(wls);
    endfunction

    // Expected parity bit for the active data bits of a character.
    function automatic logic parity_bit(input logic [7:0] data,
                                        input logic [1:0] wls,
                                        input logic       eps,
                                        input logic       sticky_parity);
        logic [7:0] mask;
        logic       x;
        mask = 8'hFF >> (2'd3 - wls);
        x    = ^(data & mask);
        if (sticky_parity)
            return ~eps;
        return eps ? x : ~x;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-flop synchroniser for the asynchronous rx pin; resets to the idle level.
module uart_rx_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] ff;

    // Shift the pin through the chain; idle-high on reset.
    always_ff @(posedge clk) begin
        if (rst)
            ff <= '1;
        else
            ff <= {ff[SYNC_STAGES-2:0], d};
    end

    assign q = ff[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_top.sv
// UART receiver: start detect, mid-bit sampling, parity/stop check, one push per frame.
module uart_rx_top
    import uart_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned OSR         = OSR_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       baud_pulse,
    input  logic       rx,
    input  logic       pen,
    input  logic       eps,
    input  logic       sticky_parity,
    input  logic [1:0] wls,
    output logic [7:0] dout,
    output logic       push,
    output logic       pe,
    output logic       fe,
    output logic       bi
);

    localparam int unsigned CW = $clog2(OSR);
    localparam logic [CW-1:0] HALF_LAST = CW'(OSR / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(OSR - 1);

    rx_state_t     state;
    logic [CW-1:0] cnt;
    logic [2:0]    bitcnt;
    logic [7:0]    shreg;
    logic          par_s;
    logic [1:0]    cfg_wls;
    logic          cfg_pen;
    logic          cfg_eps;
    logic          cfg_sticky;
    logic          rx_s;
    logic          brk_c;

    uart_rx_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    // Break: all data, parity (if any) and the stop sample are zero.
    assign brk_c = (shreg == 8'h00) && (!cfg_pen || !par_s) && !rx_s;

    // Receive FSM with tick counter, bit counter, shifter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            bitcnt     <= '0;
            shreg      <= '0;
            par_s      <= 1'b0;
            cfg_wls    <= '0;
            cfg_pen    <= 1'b0;
            cfg_eps    <= 1'b0;
            cfg_sticky <= 1'b0;
            dout       <= '0;
            push       <= 1'b0;
            pe         <= 1'b0;
            fe         <= 1'b0;
            bi         <= 1'b0;
        end else begin
            push <= 1'b0;
            if (baud_pulse) begin
                case (state)
                    IDLE: begin
                        if (!rx_s) begin
                            cnt        <= '0;
                            bitcnt     <= '0;
                            shreg      <= '0;
                            par_s      <= 1'b0;
                            cfg_wls    <= wls;
                            cfg_pen    <= pen;
                            cfg_eps    <= eps;
                            cfg_sticky <= sticky_parity;
                            state      <= START;
                        end
                    end
                    START: begin
                        if (cnt == HALF_LAST) begin
                            cnt   <= '0;
                            state <= rx_s ? IDLE : DATA;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    DATA: begin
                        if (cnt == FULL_LAST) begin
                            cnt           <= '0;
                            shreg[bitcnt] <= rx_s;
                            if ({1'b0, bitcnt} == wls_bits(cfg_wls) - 4'd1) begin
                                bitcnt <= '0;
                                state  <= cfg_pen ? PARITY : STOP;
                            end else begin
                                bitcnt <= bitcnt + 3'd1;
                            end
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    PARITY: begin
                        if (cnt == FULL_LAST) begin
                            cnt   <= '0;
                            par_s <= rx_s;
                            state <= STOP;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    STOP: begin
                        if (cnt == FULL_LAST) begin
                            cnt   <= '0;
                            push  <= 1'b1;
                            dout  <= shreg;
                            fe    <= ~rx_s;
                            pe    <= cfg_pen &
                                     (par_s != parity_bit(shreg, cfg_wls, cfg_eps, cfg_sticky));
                            bi    <= brk_c;
                            state <= brk_c ? BREAK_WAIT : IDLE;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    BREAK_WAIT: begin
                        if (rx_s)
                            state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_top.sv
// Self-checking bench for uart_rx_top: directed frames plus randomized frames vs. a frame-level model.
module tb_uart_rx_top;

    localparam int unsigned OSR      = 16;
    localparam int unsigned BAUD_DIV = 4;
    localparam int unsigned FRAME11  = 11 * OSR;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
        logic       bi;
    } rec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       baud_pulse = 1'b0;
    logic       rx = 1'b1;
    logic       pen = 1'b0;
    logic       eps = 1'b0;
    logic       sticky_parity = 1'b0;
    logic [1:0] wls = 2'b11;
    logic [7:0] dout;
    logic       push;
    logic       pe;
    logic       fe;
    logic       bi;

    rec_t got_q[$];
    int   total = 0;
    int   bad   = 0;

    uart_rx_top #(.SYNC_STAGES(2), .OSR(OSR)) dut (
        .clk           (clk),
        .rst           (rst),
        .baud_pulse    (baud_pulse),
        .rx            (rx),
        .pen           (pen),
        .eps           (eps),
        .sticky_parity (sticky_parity),
        .wls           (wls),
        .dout          (dout),
        .push          (push),
        .pe            (pe),
        .fe            (fe),
        .bi            (bi)
    );

    always #5 clk = ~clk;

    // 16x bit-rate strobe, updated on the falling edge.
    initial begin : baud_gen
        int unsigned c;
        c = 0;
        forever begin
            @(negedge clk);
            c = (c + 1) % BAUD_DIV;
            baud_pulse = (c == 0);
        end
    end

    // Record every push together with its flags.
    initial begin : push_mon
        forever begin
            @(negedge clk);
            if (push === 1'b1)
                got_q.push_back({dout, pe, fe, bi});
        end
    end

    initial begin : watchdog
        #5000000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            do @(posedge clk); while (baud_pulse !== 1'b1);
        end
        #1;
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        wait_ticks(OSR);
    endtask

    // Correct parity for n data bits: even => total ones even, sticky => ~eps.
    function automatic logic good_par(input logic [7:0] data, input int n,
                                      input logic e, input logic s);
        int ones;
        ones = $countones(data & 8'((1 << n) - 1));
        if (s)
            return ~e;
        return e ? logic'(ones % 2 == 1) : logic'(ones % 2 == 0);
    endfunction

    // Result a receiver must report for a frame described at bit level.
    function automatic rec_t model(input logic [7:0] data, input int n, input logic p,
                                   input logic e, input logic s, input logic pbit,
                                   input logic stop);
        rec_t r;
        r.d  = data & 8'((1 << n) - 1);
        r.pe = p && (pbit != good_par(data, n, e, s));
        r.fe = !stop;
        r.bi = (r.d == 8'h00) && (!p || !pbit) && !stop;
        return r;
    endfunction

    task automatic send_frame(input logic [7:0] data, input int n, input logic use_par,
                              input logic pbit, input logic stop, input bit wls_mid);
        send_bit(1'b0);
        for (int i = 0; i < n; i++) begin
            send_bit(data[i]);
            if (wls_mid && i == 0)
                wls = 2'b11;
        end
        if (use_par)
            send_bit(pbit);
        send_bit(stop);
        rx = 1'b1;
    endtask

    task automatic expect_one(input string tag, input rec_t e);
        rec_t r;
        chk({tag, "_npush"}, 32'(got_q.size()), 32'd1);
        if (got_q.size() > 0) begin
            r = got_q.pop_front();
            chk({tag, "_dout"}, 32'(r.d), 32'(e.d));
            chk({tag, "_pe"}, 32'(r.pe), 32'(e.pe));
            chk({tag, "_fe"}, 32'(r.fe), 32'(e.fe));
            chk({tag, "_bi"}, 32'(r.bi), 32'(e.bi));
        end
        got_q.delete();
    endtask

    task automatic run_frame(input string tag, input logic [7:0] data, input int n,
                             input logic pbit, input logic stop, input bit wls_mid);
        rec_t e;
        e = model(data, n, pen, eps, sticky_parity, pbit, stop);
        got_q.delete();
        send_frame(data, n, pen, pbit, stop, wls_mid);
        expect_one(tag, e);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_dout"}, 32'(dout), 32'd0);
        chk({tag, "_push"}, 32'(push), 32'd0);
        chk({tag, "_pe"}, 32'(pe), 32'd0);
        chk({tag, "_fe"}, 32'(fe), 32'd0);
        chk({tag, "_bi"}, 32'(bi), 32'd0);
    endtask

    initial begin : stim
        logic [7:0] bytes [4];
        rec_t       e;
        rec_t       r;
        logic [7:0] d;
        logic       pb;
        logic       st;
        int         n;

        // Reset values.
        rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk_reset_outs("reset");
        rst = 1'b0;
        wait_ticks(20);

        // 8E1 good frame, bad parity, bad stop.
        wls = 2'b11; pen = 1'b1; eps = 1'b1; sticky_parity = 1'b0;
        run_frame("good13", 8'h13, 8, 1'b1, 1'b1, 1'b0);
        run_frame("par13", 8'h13, 8, 1'b0, 1'b1, 1'b0);
        run_frame("stop13", 8'h13, 8, 1'b1, 1'b0, 1'b0);
        wait_ticks(20);

        // Held break: one push, then silence until a real frame.
        got_q.delete();
        rx = 1'b0;
        wait_ticks(3 * FRAME11);
        rx = 1'b1;
        expect_one("break", model(8'h00, 8, pen, eps, sticky_parity, 1'b0, 1'b0));
        wait_ticks(40);
        chk("break_quiet", 32'(got_q.size()), 32'd0);
        run_frame("after_brk", 8'hA7, 8, good_par(8'hA7, 8, eps, sticky_parity), 1'b1, 1'b0);
        wait_ticks(4);

        // 4-tick glitch: no push, receiver ready again by tick 10.
        got_q.delete();
        rx = 1'b0;
        wait_ticks(4);
        rx = 1'b1;
        wait_ticks(6);
        chk("glitch_nopush", 32'(got_q.size()), 32'd0);
        run_frame("post_glitch", 8'h3C, 8, good_par(8'h3C, 8, eps, sticky_parity), 1'b1, 1'b0);
        wait_ticks(4);

        // 5N1 with a word-length change during the frame.
        wls = 2'b00; pen = 1'b0;
        run_frame("w5", 8'h1F, 5, 1'b0, 1'b1, 1'b1);
        wait_ticks(4);

        // Back-to-back 8E1 stream.
        wls = 2'b11; pen = 1'b1; eps = 1'b1; sticky_parity = 1'b0;
        bytes[0] = 8'h00; bytes[1] = 8'h55; bytes[2] = 8'hA5; bytes[3] = 8'hFF;
        got_q.delete();
        for (int i = 0; i < 4; i++)
            send_frame(bytes[i], 8, 1'b1, good_par(bytes[i], 8, 1'b1, 1'b0), 1'b1, 1'b0);
        chk("b2b_npush", 32'(got_q.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (got_q.size() > 0) begin
                r = got_q.pop_front();
                chk($sformatf("b2b%0d_dout", i), 32'(r.d), 32'(bytes[i]));
                chk($sformatf("b2b%0d_err", i), {29'd0, r.pe, r.fe, r.bi}, 32'd0);
            end
        end
        wait_ticks(4);

        // Reset in the third frame aborts it; reception then resumes.
        got_q.delete();
        send_frame(bytes[0], 8, 1'b1, good_par(bytes[0], 8, 1'b1, 1'b0), 1'b1, 1'b0);
        send_frame(bytes[1], 8, 1'b1, good_par(bytes[1], 8, 1'b1, 1'b0), 1'b1, 1'b0);
        send_bit(1'b0);
        for (int i = 0; i < 3; i++)
            send_bit(bytes[2][i]);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rx = 1'b1;
        chk_reset_outs("midrst");
        rst = 1'b0;
        wait_ticks(2 * FRAME11);
        chk("midrst_npush", 32'(got_q.size()), 32'd2);
        run_frame("resume", bytes[3], 8, good_par(bytes[3], 8, 1'b1, 1'b0), 1'b1, 1'b0);
        wait_ticks(4);

        // Randomized configurations and frames.
        for (int k = 0; k < 16; k++) begin
            n             = int'($urandom_range(5, 8));
            wls           = 2'(n - 5);
            pen           = 1'($urandom_range(0, 1));
            eps           = 1'($urandom_range(0, 1));
            sticky_parity = 1'($urandom_range(0, 1));
            d             = 8'($urandom);
            pb            = good_par(d, n, eps, sticky_parity) ^ ($urandom_range(0, 3) == 0);
            st            = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 5) == 0) begin
                d  = 8'h00;
                pb = 1'b0;
                st = 1'b0;
            end
            e = model(d, n, pen, eps, sticky_parity, pb, st);
            got_q.delete();
            send_frame(d, n, pen, pb, st, 1'b0);
            expect_one($sformatf("rnd%0d", k), e);
            wait_ticks(6);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
